load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DMEM_WORDS, default 1024, meaning data-memory depth in 32-bit words (index = addr[31:2]).
REQ-002 The block SHALL have port i_clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, meaning reset, which SHALL be synchronous and active-high.
REQ-004 The block SHALL have EX/MEM inputs: ex_valid 1; ex_memRead 1; ex_memWrite 1; ex_size 2 (00 byte, 01 half, 10 word, 11 reserved); ex_unsigned 1; ex_addr 32; ex_storeData 32; ex_rd 5; ex_regWrite 1.
REQ-005 The block SHALL have dmem-side ports: dm_readAddress out 32; dm_writeAddress out 32; dm_writeData out 32; dm_memWrite out 1; dm_readData in 32, which is combinational from dm_readAddress.
REQ-006 The block SHALL have outputs: stall 1, meaning hold EX/MEM and upstream; misalign 1, a one-cycle fault pulse; wb_valid 1, wb_data 32, wb_rd 5 and wb_regWrite 1, forming the registered MEM/WB bundle.

Function
REQ-007 FSM states SHALL be IDLE and RMW_WR; IDLE->RMW_WR on an accepted aligned SB/SH; RMW_WR->IDLE unconditionally after one cycle.
REQ-008 An op SHALL be accepted in IDLE when ex_valid=1; no op SHALL be accepted in RMW_WR.
REQ-009 Alignment SHALL be: half requires addr[0]=0; word requires addr[1:0]=00; size 11 SHALL be treated as misaligned.
REQ-010 A misaligned op SHALL pulse misalign for 1 cycle, issue no dm_memWrite, and produce wb_valid=1 with wb_regWrite=0.
REQ-011 An aligned SW SHALL drive dm_memWrite=1, dm_writeAddress=ex_addr and dm_writeData=ex_storeData in the accept cycle, with stall=0.
REQ-012 An aligned SB/SH SHALL, in the accept cycle, drive dm_readAddress=ex_addr, latch dm_readData into merge_buf, latch the address, size and data, and assert stall=1.
REQ-013 In RMW_WR the block SHALL write merge_buf with the byte lane (addr[1:0]) or half lane (addr[1]) replaced by the low 8/16 bits of store data, assert dm_memWrite=1, keep stall=0, and leave the other lanes unchanged.
REQ-014 A load SHALL drive dm_readAddress=ex_addr in the accept cycle, with wb_data registered at the next edge (latency 1).
REQ-015 For loads, byte/half SHALL select lanes little-endian (addr[1:0]) and SHALL zero-extend if ex_unsigned=1, else sign-extend; word SHALL pass through unchanged.
REQ-016 wb_rd and wb_regWrite SHALL follow the accepted op with latency 1, and wb_valid SHALL be 1 for exactly one cycle per op, in the cycle after accept for loads/SW and the cycle after RMW_WR for SB/SH.
REQ-017 wb_regWrite SHALL be forced to 0 for stores; ex_valid=0 SHALL yield wb_valid=0 and no memory activity.
REQ-018 When not writing, dm_memWrite SHALL be 0; dm_writeAddress/dm_writeData SHALL then be don't-care but stable (hold last value).
REQ-019 ex_memRead and ex_memWrite both set SHALL be treated as a store, with the load suppressed.
REQ-020 An op arriving while stall=1 SHALL be held upstream and accepted in the first IDLE cycle.

Reset
REQ-021 On i_rst=1 at a clock edge, the state SHALL become IDLE; stall, misalign, wb_valid, wb_regWrite and dm_memWrite SHALL be 0; wb_data, wb_rd and merge_buf SHALL be 0.
REQ-022 Reset asserted in RMW_WR SHALL abort the write, so memory is unmodified.
REQ-023 While i_rst=1, dm_memWrite SHALL be 0 combinationally.

Structure
REQ-024 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and DMEM_WORDS.
REQ-025 Load lane select/extend SHALL be a sub-module load_align (in: word 32, addr_lo 2, size, unsigned; out: data 32), purely combinational.
REQ-026 The store merge SHALL stay inline, with dataMemory instantiated alongside it by the MEM-stage top level and not inside this block.

Verification
REQ-027 The bench SHALL check SW addr 0x10 data 0xDEADBEEF, then LW 0x10, giving wb_data=0xDEADBEEF one cycle after the LW accept.
REQ-028 The bench SHALL check, with mem[4]=0x11223344, SB addr 0x12 data 0xAA: stall=1 for one cycle, then mem[4]=0x11AA3344; LB 0x12 gives 0xFFFFFFAA and LBU gives 0x000000AA.
REQ-029 The bench SHALL check SH addr 0x16 data 0x8001 with mem[5]=0: mem[5]=0x80010000; LH 0x16 gives 0xFFFF8001.
REQ-030 The bench SHALL check LW 0x13 and SH 0x11: misalign pulses, no write occurs, and wb_regWrite=0.
REQ-031 The bench SHALL check SB issued, then i_rst asserted during RMW_WR: memory is unchanged and all outputs are at reset values next cycle.
REQ-032 The bench SHALL check back-to-back SB 0x20 then LW 0x20 with the LW held by stall: the LW returns the merged word.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and memory depth for the load/store unit
package lsu_pkg;

    localparam int DMEM_WORDS = 1024;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        RMW_WR
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: little-endian lane select with sign/zero extension for loads
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? word[31:16] : word[15:0];

    assign data = (size == SZ_BYTE) ? {{24{~uns & b[7]}}, b}
                : (size == SZ_HALF) ? {{16{~uns & h[15]}}, h}
                : word;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM stage with aligned loads, word stores and read-modify-write sub-word stores
module load_store_unit #(
    parameter int DMEM_WORDS = lsu_pkg::DMEM_WORDS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        ex_valid,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_storeData,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWrite,
    output logic [31:0] dm_readAddress,
    output logic [31:0] dm_writeAddress,
    output logic [31:0] dm_writeData,
    output logic        dm_memWrite,
    input  logic [31:0] dm_readData,
    output logic        stall,
    output logic        misalign,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regWrite
);

    import lsu_pkg::*;

    if (DMEM_WORDS < 1) begin : g_bad_depth
        $error("DMEM_WORDS must be positive");
    end

    lsu_state_t  state;
    logic [31:0] merge_buf;
    logic [31:0] rmw_addr;
    logic [15:0] rmw_data;
    logic [1:0]  rmw_size;
    logic [4:0]  rmw_rd;
    logic [31:0] wa_q;
    logic [31:0] wd_q;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic        accept;
    logic        is_store;
    logic        is_load;
    logic        aligned;
    logic        bad_op;
    logic        sw_now;
    logic        rmw_start;

    // A write request wins over a read request, so a combined op behaves as a store
    assign accept    = (state == IDLE) & ex_valid;
    assign is_store  = ex_memWrite;
    assign is_load   = ex_memRead & ~ex_memWrite;
    assign aligned   = (ex_size == SZ_WORD) ? (ex_addr[1:0] == 2'b00)
                     : (ex_size == SZ_HALF) ? ~ex_addr[0]
                     : (ex_size == SZ_BYTE);
    assign bad_op    = accept & (ex_memRead | ex_memWrite) & ~aligned;
    assign sw_now    = accept & is_store & aligned & (ex_size == SZ_WORD);
    assign rmw_start = accept & is_store & aligned & (ex_size != SZ_WORD);

    assign stall           = rmw_start & ~i_rst;
    assign dm_memWrite     = ~i_rst & (sw_now | (state == RMW_WR));
    assign dm_readAddress  = ex_addr;
    assign dm_writeAddress = sw_now ? ex_addr : (state == RMW_WR) ? rmw_addr : wa_q;
    assign dm_writeData    = sw_now ? ex_storeData : (state == RMW_WR) ? merged : wd_q;

    load_align u_load_align (
        .word    (dm_readData),
        .addr_lo (ex_addr[1:0]),
        .size    (ex_size),
        .uns     (ex_unsigned),
        .data    (load_data)
    );

    // Splice the stored byte or half into the word captured during the accept cycle
    always_comb begin
        merged = merge_buf;
        if (rmw_size == SZ_BYTE)
            merged[{rmw_addr[1:0], 3'b000} +: 8] = rmw_data[7:0];
        else
            merged[{rmw_addr[1], 4'b0000} +: 16] = rmw_data;
    end

    // Two-state FSM plus the registered MEM/WB bundle and held write port values
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            merge_buf   <= '0;
            rmw_addr    <= '0;
            rmw_data    <= '0;
            rmw_size    <= SZ_BYTE;
            rmw_rd      <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            misalign    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regWrite <= 1'b0;
        end else begin
            wa_q        <= dm_writeAddress;
            wd_q        <= dm_writeData;
            misalign    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (bad_op) begin
                        misalign <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_rd    <= ex_rd;
                        wb_data  <= '0;
                    end else if (rmw_start) begin
                        state     <= RMW_WR;
                        merge_buf <= dm_readData;
                        rmw_addr  <= ex_addr;
                        rmw_data  <= ex_storeData[15:0];
                        rmw_size  <= ex_size;
                        rmw_rd    <= ex_rd;
                    end else if (accept) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= ex_rd;
                        wb_regWrite <= ex_regWrite & ~is_store;
                        wb_data     <= is_load ? load_data : '0;
                    end
                end
                RMW_WR: begin
                    state    <= IDLE;
                    wb_valid <= 1'b1;
                    wb_rd    <= rmw_rd;
                    wb_data  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench with a behavioural data memory
module tb_load_store_unit;

    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_unsigned, ex_regWrite;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_storeData;
    logic [4:0]  ex_rd;
    logic [31:0] dm_readAddress, dm_writeAddress, dm_writeData, dm_readData;
    logic        dm_memWrite, stall, misalign, wb_valid, wb_regWrite;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    logic [31:0] mem [0:255];
    logic        mem_clr, poke;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } wb_t;

    wb_t sb[$];
    int  total = 0;
    int  bad = 0;

    load_store_unit dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .ex_valid        (ex_valid),
        .ex_memRead      (ex_memRead),
        .ex_memWrite     (ex_memWrite),
        .ex_size         (ex_size),
        .ex_unsigned     (ex_unsigned),
        .ex_addr         (ex_addr),
        .ex_storeData    (ex_storeData),
        .ex_rd           (ex_rd),
        .ex_regWrite     (ex_regWrite),
        .dm_readAddress  (dm_readAddress),
        .dm_writeAddress (dm_writeAddress),
        .dm_writeData    (dm_writeData),
        .dm_memWrite     (dm_memWrite),
        .dm_readData     (dm_readData),
        .stall           (stall),
        .misalign        (misalign),
        .wb_valid        (wb_valid),
        .wb_data         (wb_data),
        .wb_rd           (wb_rd),
        .wb_regWrite     (wb_regWrite)
    );

    always #5 i_clk = ~i_clk;

    assign dm_readData = mem[dm_readAddress[9:2]];

    // Behavioural data memory with a bench-side clear and preload port
    always @(posedge i_clk) begin
        if (mem_clr)
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (dm_memWrite)
            mem[dm_writeAddress[9:2]] <= dm_writeData;
        else if (poke)
            mem[poke_idx] <= poke_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic expect_wb(input logic [31:0] d, input logic [4:0] rd, input logic rw, input logic mis);
        wb_t e;
        e.data = d;
        e.rd   = rd;
        e.rw   = rw;
        e.mis  = mis;
        sb.push_back(e);
    endtask

    task automatic cyc();
        wb_t e;
        @(posedge i_clk);
        @(negedge i_clk);
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_regWrite", 32'(wb_regWrite), 32'(e.rw));
                chk("wb_misalign", 32'(misalign), 32'(e.mis));
            end
        end else begin
            chk("misalign_idle", 32'(misalign), 32'd0);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input logic rw);
        ex_valid     = 1'b1;
        ex_memRead   = r;
        ex_memWrite  = w;
        ex_size      = sz;
        ex_unsigned  = u;
        ex_addr      = a;
        ex_storeData = d;
        ex_rd        = rd;
        ex_regWrite  = rw;
    endtask

    task automatic idle();
        ex_valid    = 1'b0;
        ex_memRead  = 1'b0;
        ex_memWrite = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        idle();
        poke     = 1'b1;
        poke_idx = idx;
        poke_val = val;
        cyc();
        poke = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_regWrite"}, 32'(wb_regWrite), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_dm_memWrite"}, 32'(dm_memWrite), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1;
        mem_clr = 1'b1;
        poke = 1'b0;
        poke_idx = '0;
        poke_val = '0;
        ex_size = SZ_WORD;
        ex_unsigned = 1'b0;
        ex_addr = '0;
        ex_storeData = '0;
        ex_rd = '0;
        ex_regWrite = 1'b0;
        op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678, 5'd1, 1'b0);
        #1;
        chk("rst_comb_memWrite", 32'(dm_memWrite), 32'd0);
        cyc();
        cyc();
        mem_clr = 1'b0;
        idle();
        #1;
        chk_reset_outputs("reset");
        i_rst = 1'b0;

        // SW then LW
        op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1);
        #1;
        chk("sw_memWrite", 32'(dm_memWrite), 32'd1);
        chk("sw_waddr", dm_writeAddress, 32'h10);
        chk("sw_wdata", dm_writeData, 32'hDEADBEEF);
        chk("sw_stall", 32'(stall), 32'd0);
        expect_wb(32'h0, 5'd3, 1'b0, 1'b0);
        cyc();
        op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1);
        expect_wb(32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
        cyc();
        chk("sw_mem4", mem[4], 32'hDEADBEEF);

        // SB into a known word
        preload(8'd4, 32'h11223344);
        op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, 5'd1, 1'b1);
        #1;
        chk("sb_stall", 32'(stall), 32'd1);
        chk("sb_accept_memWrite", 32'(dm_memWrite), 32'd0);
        expect_wb(32'h0, 5'd1, 1'b0, 1'b0);
        cyc();
        #1;
        chk("sb_rmw_stall", 32'(stall), 32'd0);
        chk("sb_rmw_memWrite", 32'(dm_memWrite), 32'd1);
        chk("sb_rmw_wdata", dm_writeData, 32'h11AA3344);
        cyc();
        idle();
        chk("sb_mem4", mem[4], 32'h11AA3344);
        op(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 5'd6, 1'b1);
        expect_wb(32'hFFFFFFAA, 5'd6, 1'b1, 1'b0);
        cyc();
        op(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 5'd7, 1'b1);
        expect_wb(32'h000000AA, 5'd7, 1'b1, 1'b0);
        cyc();

        // SH into the upper half
        preload(8'd5, 32'h0);
        op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h00008001, 5'd2, 1'b1);
        #1;
        chk("sh_stall", 32'(stall), 32'd1);
        expect_wb(32'h0, 5'd2, 1'b0, 1'b0);
        cyc();
        cyc();
        idle();
        chk("sh_mem5", mem[5], 32'h80010000);
        op(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 5'd8, 1'b1);
        expect_wb(32'hFFFF8001, 5'd8, 1'b1, 1'b0);
        cyc();

        // Misaligned LW and SH
        op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 5'd9, 1'b1);
        #1;
        chk("mis_lw_memWrite", 32'(dm_memWrite), 32'd0);
        expect_wb(32'h0, 5'd9, 1'b0, 1'b1);
        cyc();
        op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000BEEF, 5'd10, 1'b1);
        #1;
        chk("mis_sh_memWrite", 32'(dm_memWrite), 32'd0);
        chk("mis_sh_stall", 32'(stall), 32'd0);
        expect_wb(32'h0, 5'd10, 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        chk("mis_mem4", mem[4], 32'h11AA3344);

        // Read and write together behaves as a store
        op(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h00000077, 5'd13, 1'b1);
        #1;
        chk("rw_memWrite", 32'(dm_memWrite), 32'd1);
        expect_wb(32'h0, 5'd13, 1'b0, 1'b0);
        cyc();
        chk("rw_mem12", mem[12], 32'h00000077);

        // Reset during RMW_WR aborts the write
        op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd12, 1'b1);
        expect_wb(32'h11AA3344, 5'd12, 1'b1, 1'b0);
        cyc();
        preload(8'd8, 32'hCAFEF00D);
        op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h00000055, 5'd4, 1'b1);
        expect_wb(32'h0, 5'd4, 1'b0, 1'b0);
        cyc();
        i_rst = 1'b1;
        #1;
        chk("abort_comb_memWrite", 32'(dm_memWrite), 32'd0);
        cyc();
        sb.delete();
        idle();
        i_rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        chk("abort_mem8", mem[8], 32'hCAFEF00D);

        // SB followed by an LW held during RMW_WR
        op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h00000055, 5'd0, 1'b0);
        expect_wb(32'h0, 5'd0, 1'b0, 1'b0);
        cyc();
        op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5'd7, 1'b1);
        expect_wb(32'hCAFEF055, 5'd7, 1'b1, 1'b0);
        #1;
        chk("b2b_rmw_stall", 32'(stall), 32'd0);
        chk("b2b_rmw_memWrite", 32'(dm_memWrite), 32'd1);
        cyc();
        cyc();
        idle();
        cyc();
        chk("b2b_mem8", mem[8], 32'hCAFEF055);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
